// File: rtl/anfsqrt_sqrecon.sv
// anfsqrt_sqrecon: rebuilds radicand = root^2 + rem one root bit per clock, MSB first,
// and flags non-canonical remainders (rem > 2*root).
module anfsqrt_sqrecon #(
    parameter int ROOT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ROOT_W-1:0]     in_root,
    input  logic [ROOT_W:0]       in_rem,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*ROOT_W-1:0]   out_radicand,
    output logic                  out_rem_err,
    output logic                  busy
);
    localparam int RW = 2 * ROOT_W;
    localparam int KW = $clog2(ROOT_W);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [RW-1:0]       acc;
    logic [RW-1:0]       acc_step;
    logic [ROOT_W-1:0]   root_q;
    logic [ROOT_W-1:0]   partial;
    logic [KW-1:0]       k;
    logic [KW:0]         sh;
    logic                err_q;

    // acc + 2*partial*att + att^2 with att = 1 << k
    always_comb begin
        sh       = {1'b0, k} + (KW+1)'(1);
        acc_step = acc + ({{ROOT_W{1'b0}}, partial} << sh) + (RW'(1) << {k, 1'b0});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            acc          <= '0;
            partial      <= '0;
            root_q       <= '0;
            k            <= '0;
            err_q        <= 1'b0;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
            out_radicand <= '0;
            out_rem_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    root_q   <= in_root;
                    acc      <= {{(ROOT_W-1){1'b0}}, in_rem};
                    partial  <= '0;
                    k        <= KW'(ROOT_W - 1);
                    err_q    <= in_rem > {in_root, 1'b0};
                    state    <= RUN;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                end
                RUN: begin
                    if (root_q[k]) begin
                        acc     <= acc_step;
                        partial <= partial | (ROOT_W'(1) << k);
                    end
                    if (k == '0) begin
                        state        <= DONE;
                        out_valid    <= 1'b1;
                        out_radicand <= root_q[k] ? acc_step : acc;
                        out_rem_err  <= err_q;
                    end else begin
                        k <= k - KW'(1);
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
